// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed host byte stream into
// little-endian 32-bit word writes, then raises start for the CPU.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic [ADDR_W:0]   words_o,
    output logic              busy_o,
    output logic              start_o,
    output logic              error_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] len_q;
    logic [1:0]  lane_q;
    logic [23:0] asm_q;
    logic        xfer;
    logic [15:0] hdr_len;
    logic        last_word;

    // Handshake and status are pure decodes of the state register.
    assign byte_ready_o = (state != S_DONE);
    assign busy_o       = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
    assign error_o      = (state == S_ERR);
    assign xfer         = byte_valid_i && byte_ready_o;
    assign hdr_len      = {byte_i, len_q[7:0]};
    assign last_word    = ((17'(words_o) + 17'd1) == 17'(len_q));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_LEN_LO;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LEN_LO: begin
                if (xfer) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (hdr_len == 16'd0) begin
                        state_next = S_DONE;
                    end else if (17'(hdr_len) > 17'(DEPTH)) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer && (lane_q == 2'd3) && last_word) state_next = S_DONE;
            end
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_LEN_LO;
        endcase
    end

    // Header capture, word assembly and the registered write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q   <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            we_o    <= 1'b0;
            waddr_o <= '0;
            wdata_o <= '0;
            words_o <= '0;
            start_o <= 1'b0;
        end else begin
            we_o <= 1'b0;
            if (state == S_DONE) start_o <= 1'b1;
            if (xfer) begin
                case (state)
                    S_LEN_LO: len_q[7:0]  <= byte_i;
                    S_LEN_HI: len_q[15:8] <= byte_i;
                    S_DATA: begin
                        lane_q <= lane_q + 2'd1;
                        case (lane_q)
                            2'd0: asm_q[7:0]   <= byte_i;
                            2'd1: asm_q[15:8]  <= byte_i;
                            2'd2: asm_q[23:16] <= byte_i;
                            default: begin
                                wdata_o <= {byte_i, asm_q};
                                we_o    <= 1'b1;
                                waddr_o <= words_o[ADDR_W-1:0];
                                words_o <= words_o + CNT_W'(1);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
